// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: pops bytes from a FIFO read port and transmits them as UART frames
// (start, 8 data LSB first, optional even parity, one stop bit).
module fifo_uart_tx #(
   parameter int CLKS_PER_BIT = 16,
   parameter bit PARITY_EN = 1'b0
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       enable,
   input  logic       fifo_empty,
   input  logic [7:0] fifo_data,
   output logic       fifo_rd,
   output logic       tx,
   output logic       busy,
   output logic       frame_done
);
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
   localparam logic [15:0] LAST = 16'(CLKS_PER_BIT - 1);
   state_t      state_q, state_d;
   logic [7:0]  shift_q, shift_d;
   logic [2:0]  idx_q, idx_d;
   logic [15:0] cnt_q, cnt_d;
   logic        par_q, par_d, tx_q, tx_d, busy_q, busy_d, done_q, done_d;
   logic        bit_end;
   assign fifo_rd    = (state_q == IDLE) & enable & ~fifo_empty & ~reset;
   assign bit_end    = (cnt_q == LAST);
   assign tx         = tx_q;
   assign busy       = busy_q;
   assign frame_done = done_q;
   always_comb begin
      state_d = state_q;
      shift_d = shift_q;
      idx_d   = idx_q;
      par_d   = par_q;
      cnt_d   = (state_q == IDLE || bit_end) ? '0 : cnt_q + 16'd1;
      case (state_q)
         IDLE: if (fifo_rd) begin
            state_d = START;
            shift_d = fifo_data;
            idx_d   = '0;
            par_d   = 1'b0;
         end
         START: if (bit_end) state_d = DATA;
         DATA: if (bit_end) begin
            // parity accumulates each bit as it leaves the shifter
            shift_d = {1'b0, shift_q[7:1]};
            par_d   = par_q ^ shift_q[0];
            idx_d   = idx_q + 3'd1;
            if (idx_q == 3'd7) state_d = PARITY_EN ? PARITY : STOP;
         end
         PARITY: if (bit_end) state_d = STOP;
         STOP: if (bit_end) state_d = IDLE;
         default: state_d = IDLE;
      endcase
      // outputs are registered, so they are decoded from the next state
      tx_d   = (state_d == START) ? 1'b0 :
               (state_d == DATA) ? shift_d[0] :
               (state_d == PARITY) ? par_d : 1'b1;
      busy_d = (state_d != IDLE);
      done_d = (state_d == STOP) && (cnt_d == LAST);
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         shift_q <= '0;
         idx_q   <= '0;
         cnt_q   <= '0;
         par_q   <= 1'b0;
         tx_q    <= 1'b1;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         par_q   <= par_d;
         tx_q    <= tx_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end
endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx: scoreboard bench; dut_a is N=4 without parity, dut_p is N=2 with parity.
module tb_fifo_uart_tx;
   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic       rst_a, en_a, empty_a, rd_a, tx_a, busy_a, done_a;
   logic [7:0] data_a;
   logic       rst_p, en_p, empty_p, rd_p, tx_p, busy_p, done_p;
   logic [7:0] data_p;
   logic [7:0] mem [16];
   logic [4:0] wp = '0, rp = '0;
   int         pushed_p = 0, popped_p = 0;
   int         cyc = 0;
   int         checks = 0, errors = 0;
   logic [7:0] exp_q [$];
   assign empty_a = (wp == rp);
   assign data_a  = mem[rp[3:0]];
   assign empty_p = (pushed_p == popped_p);
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (rd_a) rp <= rp + 5'd1;
      if (rd_p) popped_p <= popped_p + 1;
   end
   fifo_uart_tx #(.CLKS_PER_BIT(4), .PARITY_EN(1'b0)) dut_a (
      .clk(clk), .reset(rst_a), .enable(en_a), .fifo_empty(empty_a), .fifo_data(data_a),
      .fifo_rd(rd_a), .tx(tx_a), .busy(busy_a), .frame_done(done_a));
   fifo_uart_tx #(.CLKS_PER_BIT(2), .PARITY_EN(1'b1)) dut_p (
      .clk(clk), .reset(rst_p), .enable(en_p), .fifo_empty(empty_p), .fifo_data(data_p),
      .fifo_rd(rd_p), .tx(tx_p), .busy(busy_p), .frame_done(done_p));
   task automatic push_a(input logic [7:0] b);
      mem[wp[3:0]] = b;
      wp = wp + 5'd1;
      exp_q.push_back(b);
   endtask
   task automatic wait_rd(input bit p, input int limit);
      int i = 0;
      #1;
      while (!(p ? rd_p : rd_a) && i < limit) begin
         @(negedge clk); #1;
         i++;
      end
      checks++;
      if ((p ? rd_p : rd_a) !== 1'b1) begin
         errors++;
         $display("FAIL wait_rd dut%0d: fifo_rd=%b after %0d cycles, required 1", p, p ? rd_p : rd_a, limit);
      end
   endtask
   task automatic run_frame(input bit p, input int n, input logic [7:0] b, input int drop_at);
      int   len = p ? 11 * n : 10 * n;
      int   bi;
      logic e;
      for (int k = 1; k <= len; k++) begin
         @(negedge clk); #1;
         bi = (k - 1) / n;
         e = (bi == 0) ? 1'b0 : (bi <= 8) ? b[bi-1] : (p && bi == 9) ? ^b : 1'b1;
         checks++;
         if ((p ? tx_p : tx_a) !== e || (p ? busy_p : busy_a) !== 1'b1 ||
             (p ? done_p : done_a) !== (k == len) || (p ? rd_p : rd_a) !== 1'b0) begin
            errors++;
            $display("FAIL frame dut%0d byte %02h cycle T+%0d: tx=%b busy=%b done=%b rd=%b, required tx=%b busy=1 done=%b rd=0",
                     p, b, k, p ? tx_p : tx_a, p ? busy_p : busy_a, p ? done_p : done_a, p ? rd_p : rd_a, e, k == len);
         end
         if (k == drop_at) en_a = 1'b0;
      end
   endtask
   task automatic check_idle(input string name, input logic rd_req);
      @(negedge clk); #1;
      checks++;
      if (tx_a !== 1'b1 || busy_a !== 1'b0 || done_a !== 1'b0 || rd_a !== rd_req) begin
         errors++;
         $display("FAIL %s: tx=%b busy=%b done=%b rd=%b, required tx=1 busy=0 done=0 rd=%b",
                  name, tx_a, busy_a, done_a, rd_a, rd_req);
      end
   endtask
   task automatic test_reset;
      rst_a = 1'b1;
      en_a  = 1'b1;
      push_a(8'hA5);
      repeat (3) check_idle("reset_hold", 1'b0);
      rst_a = 1'b0;
      rst_p = 1'b0;
      #1;
      checks++;
      if (rd_a !== 1'b1) begin
         errors++;
         $display("FAIL first_rd_after_reset: fifo_rd=%b, required 1", rd_a);
      end
   endtask
   task automatic test_single;
      run_frame(1'b0, 4, exp_q.pop_front(), -1);
      check_idle("single_one_rd", 1'b0);
   endtask
   task automatic test_back_to_back;
      int t1;
      push_a(8'h00);
      push_a(8'hFF);
      wait_rd(1'b0, 5);
      t1 = cyc;
      run_frame(1'b0, 4, exp_q.pop_front(), -1);
      check_idle("b2b_gap", 1'b1);
      checks++;
      if (cyc - t1 !== 41) begin
         errors++;
         $display("FAIL b2b_period: %0d cycles, required 41", cyc - t1);
      end
      run_frame(1'b0, 4, exp_q.pop_front(), -1);
      check_idle("b2b_end", 1'b0);
   endtask
   task automatic test_parity;
      data_p = 8'h07;
      exp_q.push_back(8'h07);
      pushed_p = pushed_p + 1;
      en_p = 1'b1;
      wait_rd(1'b1, 5);
      run_frame(1'b1, 2, exp_q.pop_front(), -1);
      @(negedge clk); #1;
      checks++;
      if (tx_p !== 1'b1 || busy_p !== 1'b0 || rd_p !== 1'b0) begin
         errors++;
         $display("FAIL parity_end: tx=%b busy=%b rd=%b, required 1 0 0", tx_p, busy_p, rd_p);
      end
   endtask
   task automatic test_enable;
      en_a = 1'b0;
      push_a(8'h3C);
      push_a(8'h5A);
      repeat (50) check_idle("enable_low", 1'b0);
      en_a = 1'b1;
      #1;
      checks++;
      if (rd_a !== 1'b1) begin
         errors++;
         $display("FAIL enable_latency: fifo_rd=%b, required 1", rd_a);
      end
      run_frame(1'b0, 4, exp_q.pop_front(), 3 * 4 + 2);
      repeat (50) check_idle("enable_dropped", 1'b0);
   endtask
   task automatic test_reset_mid;
      logic [7:0] b;
      push_a(8'hC3);
      en_a = 1'b1;
      wait_rd(1'b0, 2);
      b = exp_q.pop_front();
      repeat (5 * 4 + 1) @(negedge clk);
      #1;
      checks++;
      if (tx_a !== b[4] || busy_a !== 1'b1) begin
         errors++;
         $display("FAIL abort_bit4: tx=%b busy=%b, required tx=%b busy=1", tx_a, busy_a, b[4]);
      end
      rst_a = 1'b1;
      check_idle("reset_mid", 1'b0);
      rst_a = 1'b0;
      #1;
      checks++;
      if (rd_a !== 1'b1) begin
         errors++;
         $display("FAIL rd_after_abort: fifo_rd=%b, required 1", rd_a);
      end
      run_frame(1'b0, 4, exp_q.pop_front(), -1);
      check_idle("after_abort_end", 1'b0);
      checks++;
      if (exp_q.size() != 0 || wp != rp) begin
         errors++;
         $display("FAIL scoreboard_drain: %0d expected bytes left, fifo wp=%0d rp=%0d", exp_q.size(), wp, rp);
      end
   endtask
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end
   initial begin
      rst_a = 1'b1;
      rst_p = 1'b1;
      en_a = 1'b0;
      en_p = 1'b0;
      data_p = 8'h00;
      test_reset;
      test_single;
      test_back_to_back;
      test_parity;
      test_enable;
      test_reset_mid;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/fifo_uart_tx.md
# fifo_uart_tx

Consumer on the read side of the 16-entry byte FIFO. Whenever the FIFO is non-empty and the block is enabled, it pops one byte and sends it serially on `tx` as an asynchronous UART frame: start bit, 8 data bits LSB first, optional even parity, one stop bit. It sits between the FIFO read port (`rd`, `data_out`, `fifo_empty`) and the chip's serial output pin.

## Interface
- `CLKS_PER_BIT`, default 16: clock cycles per serial bit. Legal range is 2..65535, held in a 16-bit counter.
- `PARITY_EN`, default 0: when 1, an even-parity bit is inserted between data bit 7 and the stop bit.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `enable`  in  1  permits fetching new bytes from the FIFO.
- `fifo_empty`  in  1  FIFO empty flag.
- `fifo_data`  in  8  FIFO `data_out`. Combinational; valid whenever `fifo_empty`=0.
- `fifo_rd`  out  1  FIFO read strobe, one cycle per byte.
- `tx`  out  1  serial line; idle level is high.
- `busy`  out  1  high while a frame is in progress.
- `frame_done`  out  1  one-cycle pulse on the last cycle of the stop bit.

## Operation
- States: IDLE, START, DATA, PARITY, STOP.
- Registers: 8-bit shift register, 3-bit bit index, 16-bit cycle counter, parity accumulator.
- IDLE:
  - `fifo_rd` = `enable` & ~`fifo_empty` & ~`reset`. This is a combinational decode of the IDLE state.
  - In a cycle where `fifo_rd`=1, `fifo_data` is latched into the shift register at that edge, and the next state is START.
- START: `tx`=0 for `CLKS_PER_BIT` cycles, then DATA.
- DATA:
  - `tx` = shift_reg[0]. The register shifts right once per completed bit.
  - After 8 bits, go to PARITY if `PARITY_EN`, else to STOP.
- PARITY: `tx` = XOR of the 8 latched data bits (even parity), for `CLKS_PER_BIT` cycles.
- STOP: `tx`=1 for `CLKS_PER_BIT` cycles. `frame_done`=1 in its final cycle. Then return to IDLE.
- Bit counter counts 0..`CLKS_PER_BIT`-1 and wraps to 0 at each bit boundary.
- `busy` = (state != IDLE).
- `enable` deasserted mid-frame: the current frame completes normally; no new fetch happens until `enable`=1.
- `fifo_empty` is ignored outside IDLE. No underflow is possible, because `fifo_rd` is only issued when the FIFO is non-empty.
- Reset mid-frame:
  - Next cycle: state IDLE, `tx`=1, `busy`=0, `frame_done`=0.
  - The byte in flight is dropped. The FIFO pointer has already advanced, so the byte is not re-read.
- Reset values: `tx`=1, `fifo_rd`=0, `busy`=0, `frame_done`=0, shift register 0, counters 0.

## Timing
- `tx`, `busy` and `frame_done` are registered. `fifo_rd` is combinational from state and inputs.
- Let T be the cycle with `fifo_rd`=1 and N = `CLKS_PER_BIT`.
- Frame layout from T:
  - Start bit occupies cycles T+1..T+N.
  - Data bit i occupies cycles T+1+N(1+i) .. T+N(2+i).
  - Without parity, the stop bit occupies T+1+9N .. T+10N.
  - With parity, the parity bit occupies T+1+9N .. T+10N and the stop bit T+1+10N .. T+11N.
- `frame_done` is high in cycle T+10N (or T+11N with parity). The FSM is in IDLE in the following cycle.
- Back-to-back with the FIFO non-empty: the next `fifo_rd` is at T+10N+1 (or T+11N+1). The frame period is 10N+1 cycles (or 11N+1), and there is exactly one idle-high cycle between stop and start.
- Latency from `fifo_empty` falling (with `enable`=1, in IDLE) to `fifo_rd`: 0 cycles. From `fifo_rd` to `tx` falling: 1 cycle.

## Test plan
- Reset values: hold `reset` for 3 cycles with `fifo_empty`=0 and `enable`=1. Required: `fifo_rd`=0, `tx`=1 and `busy`=0 during reset; the first `fifo_rd` comes in the first cycle after reset.
- Single byte, N=4, no parity, byte 0xA5:
  - `tx` sequence per 4-cycle bit: 0, 1,0,1,0,0,1,0,1, 1.
  - `frame_done` at T+40; `busy` is high over T+1..T+40.
  - Exactly one `fifo_rd` pulse.
- Back-to-back 0x00 then 0xFF, N=4: two `fifo_rd` pulses exactly 41 cycles apart, with one high cycle between the first stop bit and the second start bit.
- `PARITY_EN`=1, N=2, byte 0x07:
  - Parity bit is 1, on cycles T+19..T+20.
  - Stop bit on T+21..T+22; `frame_done` at T+22.
- `enable` behaviour:
  - `enable`=0 with the FIFO non-empty for 50 cycles: no `fifo_rd`, `tx` stays 1.
  - Drop `enable` during the 3rd data bit: the frame finishes and no further `fifo_rd` is issued.
- Reset during data bit 4, N=4: the next cycle shows `tx`=1 and `busy`=0. After release, the next FIFO byte is sent intact and the aborted byte is not resent.
